// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Decade clamp and FSM state encoding.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] nibble
  );
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle of the BCD countdown timer.
// master drives the controls, slave is the timer.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 3
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  start;
  logic                  stop;
  logic                  tick;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  expired;
  logic                  done;
  logic                  err;

  modport master (
    output load, load_val, start, stop, tick,
    input  count, running, expired, done, err
  );

  modport slave (
    input  load, load_val, start, stop, tick,
    output count, running, expired, done, err
  );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD decade of the down-counter.
// Wraps 0 -> 9 and flags a borrow into the next decade.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow_out
);

  assign borrow_out = dec & (q == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= load_digit;
    end else if (dec) begin
      q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Loadable multi-decade BCD countdown timer.
// Start/stop/expiry FSM with optional auto-reload.
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS      = 3,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_countdown_timer_if.slave  bus
);

  localparam int W = 4 * DIGITS;

  state_t         state;
  logic [W-1:0]   reload;
  logic [W-1:0]   clamped;
  logic [W-1:0]   load_digits;
  wire  [W-1:0]   count;
  wire  [DIGITS:0] borrow;
  logic           any_big;
  logic           nonzero;
  logic           is_one;
  logic           run_tick;
  logic           reload_now;
  logic           dig_load;
  logic           done_q;
  logic           err_q;
  logic           unused_borrow;

  always_comb begin
    clamped = '0;
    any_big = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      clamped[4*k +: 4] = bcd_clamp(bus.load_val[4*k +: 4]);
      if (bus.load_val[4*k +: 4] > BCD_MAX) begin
        any_big = 1'b1;
      end
    end
  end

  assign nonzero  = |count;
  assign is_one   = (count == W'(1));
  assign run_tick = ~bus.load & ~bus.stop & ~bus.start
                  & bus.tick & (state == RUN);

  // Reload from the stored value: tick at zero, or restart after expiry.
  assign reload_now = (run_tick & ~nonzero)
                    | (~bus.load & ~bus.stop & bus.start
                       & (state == EXPIRED));

  assign dig_load    = bus.load | reload_now;
  assign load_digits = bus.load ? clamped : reload;
  assign borrow[0]   = run_tick & nonzero;
  assign unused_borrow = borrow[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (dig_load),
      .load_digit (load_digits[4*k +: 4]),
      .dec        (borrow[k]),
      .q          (count[4*k +: 4]),
      .borrow_out (borrow[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      reload <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (bus.load) begin
        state  <= IDLE;
        reload <= clamped;
        err_q  <= any_big;
      end else if (bus.stop) begin
        state <= IDLE;
      end else if (bus.start) begin
        case (state)
          IDLE:    state <= nonzero ? RUN : EXPIRED;
          EXPIRED: state <= (|reload) ? RUN : EXPIRED;
          default: state <= state;
        endcase
      end else if (run_tick) begin
        if (!nonzero) begin
          done_q <= ~|reload;
        end else if (is_one) begin
          done_q <= 1'b1;
          if (!AUTO_RELOAD) begin
            state <= EXPIRED;
          end
        end
      end
    end
  end

  assign bus.count   = count;
  assign bus.running = (state == RUN);
  assign bus.expired = (state == EXPIRED);
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: a one-shot and an auto-reload
// instance share stimulus and are checked against a decimal model.
module tb_bcd_countdown_timer;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_EXP  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;
  logic [11:0] load_val = '0;

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt [2];
  int m_rl  [2];
  int m_st  [2];
  bit m_done[2];
  bit m_err [2];

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.DIGITS(3)) ifa ();
  bcd_countdown_timer_if #(.DIGITS(3)) ifb ();

  assign ifa.load = load;
  assign ifa.load_val = load_val;
  assign ifa.start = start;
  assign ifa.stop = stop;
  assign ifa.tick = tick;
  assign ifb.load = load;
  assign ifb.load_val = load_val;
  assign ifb.start = start;
  assign ifb.stop = stop;
  assign ifb.tick = tick;

  bcd_countdown_timer #(
    .DIGITS(3), .AUTO_RELOAD(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  bcd_countdown_timer #(
    .DIGITS(3), .AUTO_RELOAD(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] m_flags(input int i);
    return {m_st[i] == S_RUN, m_st[i] == S_EXP,
            m_done[i], m_err[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_rl[i] = 0;
      m_st[i] = S_IDLE;
      m_done[i] = 1'b0;
      m_err[i] = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int v;
      int nib;
      m_done[i] = 1'b0;
      m_err[i] = 1'b0;
      if (load) begin
        v = 0;
        for (int k = 2; k >= 0; k--) begin
          nib = int'(load_val[4*k +: 4]);
          if (nib > 9) begin
            nib = 9;
            m_err[i] = 1'b1;
          end
          v = v * 10 + nib;
        end
        m_cnt[i] = v;
        m_rl[i] = v;
        m_st[i] = S_IDLE;
      end else if (stop) begin
        m_st[i] = S_IDLE;
      end else if (start) begin
        if (m_st[i] == S_IDLE) begin
          m_st[i] = (m_cnt[i] != 0) ? S_RUN : S_EXP;
        end else if (m_st[i] == S_EXP) begin
          m_cnt[i] = m_rl[i];
          m_st[i] = (m_rl[i] != 0) ? S_RUN : S_EXP;
        end
      end else if (tick && m_st[i] == S_RUN) begin
        if (m_cnt[i] == 0) begin
          m_cnt[i] = m_rl[i];
          m_done[i] = (m_rl[i] == 0);
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_done[i] = 1'b1;
            if (i == 0) m_st[i] = S_EXP;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic l, input logic [11:0] lv,
                       input logic s, input logic p,
                       input logic t);
    load = l;
    load_val = lv;
    start = s;
    stop = p;
    tick = t;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    drive(0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ifa.count, ifa.running, ifa.expired, ifa.done, ifa.err}
        !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_a: got %h/%b%b%b%b want 000/0000",
               ifa.count, ifa.running, ifa.expired,
               ifa.done, ifa.err);
    end
    n_tests++;
    if ({ifb.count, ifb.running, ifb.expired, ifb.done, ifb.err}
        !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_b: got %h/%b%b%b%b want 000/0000",
               ifb.count, ifb.running, ifb.expired,
               ifb.done, ifb.err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_countdown();
    drive(1, 12'h005, 0, 0, 0);
    step();
    drive(0, '0, 1, 0, 0);
    step();
    drive(0, '0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (ifa.count !== to_bcd(4 - i) ||
          ifa.done !== (i == 4)) begin
        n_fail++;
        $display("FAIL countdown tick %0d: got %h d=%b want %h d=%b",
                 i, ifa.count, ifa.done, to_bcd(4 - i), i == 4);
      end
      n_tests++;
      if (ifb.count !== to_bcd(m_cnt[1]) ||
          ifb.done !== m_done[1]) begin
        n_fail++;
        $display("FAIL countdown_b tick %0d: got %h want %h",
                 i, ifb.count, to_bcd(m_cnt[1]));
      end
    end
    n_tests++;
    if (ifa.expired !== 1'b1 || ifa.running !== 1'b0 ||
        ifb.running !== 1'b1) begin
      n_fail++;
      $display("FAIL expiry flags: got a=%b%b b_run=%b want 01/1",
               ifa.running, ifa.expired, ifb.running);
    end
    repeat (2) begin
      step();
      n_tests++;
      if (ifa.count !== 12'h000 || ifa.done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_zero: got %h d=%b want 000 d=0",
                 ifa.count, ifa.done);
      end
    end
    drive(0, '0, 0, 0, 0);
  endtask

  task automatic test_borrow();
    logic [11:0] vals [3] = '{12'h100, 12'h010, 12'h999};
    logic [11:0] exps [3] = '{12'h099, 12'h009, 12'h998};
    for (int i = 0; i < 3; i++) begin
      drive(1, vals[i], 0, 0, 0);
      step();
      drive(0, '0, 1, 0, 0);
      step();
      drive(0, '0, 0, 0, 1);
      step();
      drive(0, '0, 0, 0, 0);
      n_tests++;
      if (ifa.count !== exps[i] || ifb.count !== exps[i]) begin
        n_fail++;
        $display("FAIL borrow %h: got a=%h b=%h want %h",
                 vals[i], ifa.count, ifb.count, exps[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [11:0] vals [2] = '{12'h1A3, 12'h2F0};
    logic [11:0] exps [2] = '{12'h193, 12'h290};
    for (int i = 0; i < 2; i++) begin
      drive(1, vals[i], 0, 0, 0);
      step();
      drive(0, '0, 0, 0, 0);
      n_tests++;
      if (ifa.count !== exps[i] || ifa.err !== 1'b1 ||
          ifa.running !== 1'b0) begin
        n_fail++;
        $display("FAIL clamp %h: got %h err=%b want %h err=1",
                 vals[i], ifa.count, ifa.err, exps[i]);
      end
      step();
      n_tests++;
      if (ifa.err !== 1'b0 || ifb.err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse: got a=%b b=%b want 0",
                 ifa.err, ifb.err);
      end
    end
  endtask

  task automatic test_auto_reload();
    logic [11:0] exps [6] = '{12'h001, 12'h000, 12'h002,
                              12'h001, 12'h000, 12'h002};
    logic        dn   [6] = '{0, 1, 0, 0, 1, 0};
    drive(1, 12'h002, 0, 0, 0);
    step();
    drive(0, '0, 1, 0, 0);
    step();
    drive(0, '0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if (ifb.count !== exps[i] || ifb.done !== dn[i] ||
          ifb.running !== 1'b1) begin
        n_fail++;
        $display("FAIL auto %0d: got %h d=%b r=%b want %h d=%b r=1",
                 i, ifb.count, ifb.done, ifb.running,
                 exps[i], dn[i]);
      end
    end
    n_tests++;
    if (ifa.count !== 12'h000 || ifa.expired !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_stop: got %h e=%b want 000 e=1",
               ifa.count, ifa.expired);
    end
    drive(0, '0, 0, 0, 0);
  endtask

  task automatic test_stop();
    drive(1, 12'h050, 0, 0, 0);
    step();
    drive(0, '0, 1, 0, 0);
    step();
    drive(0, '0, 0, 1, 1);
    step();
    n_tests++;
    if (ifa.count !== 12'h050 || ifa.running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_tick: got %h r=%b want 050 r=0",
               ifa.count, ifa.running);
    end
    drive(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (ifa.count !== 12'h050 || ifb.count !== 12'h050) begin
      n_fail++;
      $display("FAIL idle_tick: got a=%h b=%h want 050",
               ifa.count, ifb.count);
    end
    drive(0, '0, 1, 0, 0);
    step();
    drive(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (ifa.count !== 12'h049 || ifa.running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got %h r=%b want 049 r=1",
               ifa.count, ifa.running);
    end
    drive(0, '0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    logic [11:0] lv;
    drive(1, 12'h003, 0, 0, 0);
    step();
    drive(0, '0, 1, 0, 0);
    step();
    drive(0, '0, 0, 0, 1);
    step();
    n_tests++;
    if (ifa.count !== 12'h002) begin
      n_fail++;
      $display("FAIL pre_reset: got %h want 002", ifa.count);
    end
    drive(0, '0, 0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({ifa.count, ifa.running, ifa.expired, ifa.done, ifa.err,
         ifb.count, ifb.running, ifb.expired, ifb.done, ifb.err}
        !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%h/%b b=%h/%b want 0",
               ifa.count, ifa.running, ifb.count, ifb.running);
    end
    @(negedge clk);
    rst = 1'b1;
    lv = to_bcd(int'($urandom_range(1, 999)));
    drive(1, lv, 1, 0, 0);
    step();
    drive(0, '0, 0, 0, 0);
    n_tests++;
    if (ifa.count !== lv || ifa.running !== 1'b0 ||
        ifb.running !== 1'b0) begin
      n_fail++;
      $display("FAIL load_start: got %h r=%b want %h r=0",
               ifa.count, ifa.running, lv);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 15) == 0,
            12'($urandom),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) load_val = to_bcd(
        int'($urandom_range(0, 12)));
      step();
      n_tests++;
      if (ifa.count !== to_bcd(m_cnt[0]) ||
          {ifa.running, ifa.expired, ifa.done, ifa.err}
          !== m_flags(0)) begin
        n_fail++;
        $display("FAIL random_a c=%0d: got %h/%b%b%b%b want %h/%b",
                 c, ifa.count, ifa.running, ifa.expired,
                 ifa.done, ifa.err, to_bcd(m_cnt[0]), m_flags(0));
      end
      n_tests++;
      if (ifb.count !== to_bcd(m_cnt[1]) ||
          {ifb.running, ifb.expired, ifb.done, ifb.err}
          !== m_flags(1)) begin
        n_fail++;
        $display("FAIL random_b c=%0d: got %h/%b%b%b%b want %h/%b",
                 c, ifb.count, ifb.running, ifb.expired,
                 ifb.done, ifb.err, to_bcd(m_cnt[1]), m_flags(1));
      end
    end
    drive(0, '0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_clamp();
    test_auto_reload();
    test_stop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Loadable multi-decade BCD down-counter (countdown timer). It is the decrementing counterpart of the team's BCD up-counter chain.
- A parameterised number of decimal digits counts down once per `tick` strobe, with borrow rippling between decades.
- A small FSM handles start, stop and expiry, with optional auto-reload.
- Drives the same seven-segment/digit display path as the up-counter; `done` feeds interrupt and timeout logic.

Parameters:
- DIGITS, 3, number of BCD decades (1..6); digit 0 is ones.
- AUTO_RELOAD, 0, 1 = reload from the stored value and keep running after expiry; 0 = stop at expiry.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- load  input  1  load `load_val` into the count and reload register.
- load_val  input  4*DIGITS  BCD load value; nibble k is decade k.
- start  input  1  begin/resume counting.
- stop  input  1  pause counting.
- tick  input  1  count strobe; one decrement per cycle in which it is high while RUN.
- count  output  4*DIGITS  current BCD count, registered.
- running  output  1  state == RUN.
- expired  output  1  state == EXPIRED.
- done  output  1  one-cycle pulse, registered.
- err  output  1  one-cycle pulse, registered; `load_val` contained a digit > 9.

Behaviour:
- Reset (rst = 0, asynchronous):
  - count = 0, reload register = 0, state = IDLE.
  - running, expired, done and err = 0.
- Input priority per cycle: load > stop > start > tick.
- load (any state):
  - Each digit of `load_val` greater than 9 is clamped to 9.
  - count and the reload register take the clamped value; state goes to IDLE.
  - err = 1 next cycle if any digit was clamped; done = 0.
- Decrement, when in RUN with tick = 1:
  - Digit 0 always decrements.
  - Digit k decrements iff digits 0..k-1 are all 0.
  - A digit at 0 that decrements wraps to 9.
  - The count never decrements when it is all zeros.
- FSM:
  - IDLE:
    - start with count ≠ 0 goes to RUN.
    - start with count = 0 goes to EXPIRED, with no done pulse.
    - tick is ignored.
  - RUN:
    - stop goes to IDLE with count held.
    - tick with count = 1 decrements to 0. With AUTO_RELOAD = 0 the state goes to EXPIRED; with AUTO_RELOAD = 1 it stays in RUN. In both cases done = 1 in the first cycle count reads 0.
    - tick with count = 0 (only reachable with AUTO_RELOAD = 1) loads count from the reload register. If the reload value is 0, done pulses on every tick. The period is reload+1 ticks.
  - EXPIRED:
    - count holds 0.
    - start reloads count from the reload register and goes to RUN; if the reload value is 0, it goes to EXPIRED.
    - load goes to IDLE.
    - stop goes to IDLE.
- Latency: every output is registered and reflects the inputs one clock after they are sampled.
- Simultaneous events:
  - load with start: load wins and the state is IDLE. start must be reasserted.
  - stop with tick: no decrement.
- Reset mid-count clears everything immediately, with no done pulse.
- With all digits at 9 (999), one tick gives 998.

Decomposition:
- Package `bcd_pkg`:
  - state enum {IDLE, RUN, EXPIRED} as a 2-bit typedef;
  - BCD_MAX = 4'd9;
  - function `bcd_clamp(nibble)`.
- Sub-module `bcd_down_digit`, instantiated DIGITS times in a generate loop:
  - ports: clk, rst (active-low async), load, load_digit, dec, q, borrow_out;
  - borrow_out = dec & (q == 0);
  - `dec` of digit k is the `borrow_out` of digit k-1; digit 0 gets RUN & tick & (count ≠ 0).
  - The top level handles reload-at-zero by asserting `load` on all digits.

Test Plan:
1. Reset, then load 005, start, apply 5 ticks → count 004, 003, 002, 001, 000. done is high in the cycle count shows 000. Then expired = 1 and running = 0; further ticks keep 000.
2. Load 100, start, 1 tick → 099. Load 010, 1 tick → 009. Both check borrow across decades and 0→9 wrap.
3. Load `load_val` = 0x1A3 → count 193, err pulses one cycle. Load 0x2F0 → 290, err pulses.
4. With AUTO_RELOAD = 1, load 002, start, 6 ticks → 001, 000 (done), 002, 001, 000 (done), 002. running stays 1.
5. Load 050, start, tick with stop asserted → count stays 050, state IDLE. Tick while IDLE → 050. Start and tick → 049.
6. Load 003, start, 1 tick, then reset low asynchronously mid-cycle → count 000 and all flags 0 immediately. Load with start in the same cycle → count equals `load_val`, running = 0.
